pc_fetch_unit: RTL and testbench

- Holds the architectural program counter (CurrentPC) and drives instruction fetch for the LEGv8 single-cycle core.
- Consumes the NextPC value produced by the next-PC logic, with one outstanding instruction-memory request at a time.
- Presents each fetched instruction, together with its PC, to decode under a valid/ready handshake.
- Sits between the next-PC logic and instruction memory; it is the register/fetch end of the NextPC interface.

---
 rtl/pc_fetch_unit_pkg.sv | 22 ++
 rtl/pc_fetch_unit.sv | 72 +++++++
 tb/tb_pc_fetch_unit.sv | 268 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/pc_fetch_unit_pkg.sv
// Shared types and constants for the LEGv8 PC/fetch unit.
// Holds the fetch FSM encoding and the PC alignment rule.
package pc_fetch_unit_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_HOLD,
    S_FAULT
  } fetch_state_e;

  localparam int PC_W        = 64;
  localparam int INSTR_BYTES = 4;
  localparam int ALIGN_W     = $clog2(INSTR_BYTES);
  localparam logic [ALIGN_W-1:0] ALIGN_OK = 2'b00;

  function automatic logic pc_aligned(input logic [PC_W-1:0] pc);
    return pc[ALIGN_W-1:0] == ALIGN_OK;
  endfunction

endpackage

// File: rtl/pc_fetch_unit.sv
// Architectural PC register and single-outstanding instruction fetch FSM.
// Fetched words are handed to decode under valid/ready; a misaligned PC is a sticky fault.
module pc_fetch_unit
  import pc_fetch_unit_pkg::*;
#(
  parameter logic [PC_W-1:0] RESET_PC = '0,
  parameter int              INSTR_W  = 32
) (
  input  logic               CLK,
  input  logic               Reset,
  output logic [PC_W-1:0]    CurrentPC,
  input  logic [PC_W-1:0]    NextPC,
  output logic               imem_req_valid,
  input  logic               imem_req_ready,
  output logic [PC_W-1:0]    imem_addr,
  input  logic               imem_rsp_valid,
  input  logic [INSTR_W-1:0] imem_rsp_data,
  output logic               instr_valid,
  input  logic               instr_ready,
  output logic [INSTR_W-1:0] instr,
  output logic [PC_W-1:0]    instr_pc,
  output logic               fetch_fault
);

  fetch_state_e        r_state;
  fetch_state_e        w_state_nxt;
  logic [PC_W-1:0]     r_pc;
  logic [INSTR_W-1:0]  r_instr;
  logic                w_pc_ld;
  logic                w_instr_ld;

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      r_state <= S_IDLE;
      r_pc    <= RESET_PC;
      r_instr <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_pc_ld)    r_pc    <= NextPC;
      if (w_instr_ld) r_instr <= imem_rsp_data;
    end
  end

  // Responses outside WAIT are stray and dropped; only one request may be in flight.
  always_comb begin
    w_state_nxt = r_state;
    w_pc_ld     = 1'b0;
    w_instr_ld  = 1'b0;
    unique case (r_state)
      S_IDLE: w_state_nxt = pc_aligned(RESET_PC) ? S_REQ : S_FAULT;
      S_REQ:  if (imem_req_ready) w_state_nxt = S_WAIT;
      S_WAIT: if (imem_rsp_valid) begin
        w_instr_ld  = 1'b1;
        w_state_nxt = S_HOLD;
      end
      S_HOLD: if (instr_ready) begin
        w_pc_ld     = 1'b1;
        w_state_nxt = pc_aligned(NextPC) ? S_REQ : S_FAULT;
      end
      default: w_state_nxt = S_FAULT;
    endcase
  end

  assign CurrentPC      = r_pc;
  assign imem_addr      = r_pc;
  assign instr_pc       = r_pc;
  assign instr          = r_instr;
  assign imem_req_valid = (r_state == S_REQ);
  assign instr_valid    = (r_state == S_HOLD);
  assign fetch_fault    = (r_state == S_FAULT);

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Randomized scoreboard bench for pc_fetch_unit: a behavioural memory and decode
// drive the DUT, a separate monitor compares requests/deliveries against expected queues.
module tb_pc_fetch_unit;

  localparam logic [63:0] RST_PC = 64'h0;

  logic        CLK = 1'b0;
  logic        Reset;
  logic [63:0] CurrentPC;
  logic [63:0] NextPC;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [63:0] imem_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [63:0] instr_pc;
  logic        fetch_fault;

  pc_fetch_unit #(.RESET_PC(RST_PC), .INSTR_W(32)) dut (
    .CLK(CLK), .Reset(Reset), .CurrentPC(CurrentPC), .NextPC(NextPC),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
    .imem_addr(imem_addr), .imem_rsp_valid(imem_rsp_valid),
    .imem_rsp_data(imem_rsp_data), .instr_valid(instr_valid),
    .instr_ready(instr_ready), .instr(instr), .instr_pc(instr_pc),
    .fetch_fault(fetch_fault)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [63:0] pc;
    logic [31:0] ins;
  } exp_t;

  exp_t        exp_q[$];
  logic [63:0] addr_q[$];

  int checks = 0;
  int errors = 0;
  int n_deliv = 0;

  // memory / decode model state
  bit          outst = 0;
  int          lat = 0;
  logic [63:0] req_addr = '0;
  logic [63:0] model_pc = RST_PC;
  int p_rdy = 100, max_lat = 0, p_dec = 0, spur = 0, br = 0;
  bit mis_en = 0, force_en = 0;
  logic [63:0] force_pc = '0;

  function automatic logic [31:0] mem_word(input logic [63:0] a);
    return (a[31:0] * 32'h9E3779B1) ^ a[63:32] ^ 32'h8B020020;
  endfunction

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", nm, got, exp);
    end
  endtask

  // One cycle of memory and decode behaviour, inputs changed just after negedge.
  task automatic step();
    logic [63:0] np;
    @(negedge CLK); #1;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = $urandom;
    if (outst) begin
      if (lat == 0) begin
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = mem_word(req_addr);
        outst = 0;
      end else lat--;
    end else if ((instr_valid || imem_req_valid) && ($urandom_range(0, 99) < spur)) begin
      imem_rsp_valid = 1'b1;
    end
    imem_req_ready = ($urandom_range(0, 99) < p_rdy);
    if (imem_req_valid && imem_req_ready) begin
      outst    = 1;
      lat      = $urandom_range(0, max_lat);
      req_addr = imem_addr;
    end
    instr_ready = ($urandom_range(0, 99) < p_dec);
    if (force_en)                          np = force_pc;
    else if (mis_en)                       np = 64'h42;
    else if ($urandom_range(0, 99) < br)   np = {$urandom, $urandom} & ~64'h3;
    else                                   np = model_pc + 64'd4;
    NextPC = instr_ready ? np : {$urandom, $urandom};
    if (instr_valid && instr_ready) begin
      force_en = 0;
      model_pc = np;
      if (np[1:0] == 2'b00) begin
        exp_q.push_back('{np, mem_word(np)});
        addr_q.push_back(np);
      end
    end
  endtask

  task automatic do_reset();
    Reset = 1'b1;
    imem_rsp_valid = 1'b0;
    imem_req_ready = 1'b0;
    instr_ready = 1'b0;
    outst = 0;
    exp_q.delete();
    addr_q.delete();
    model_pc = RST_PC;
    repeat (2) @(negedge CLK);
    #1 Reset = 1'b0;
    exp_q.push_back('{RST_PC, mem_word(RST_PC)});
    addr_q.push_back(RST_PC);
  endtask

  task automatic chk_reset_outputs(input string nm);
    chk({nm, "_reqv"}, 64'(imem_req_valid), 64'd0);
    chk({nm, "_ivalid"}, 64'(instr_valid), 64'd0);
    chk({nm, "_fault"}, 64'(fetch_fault), 64'd0);
    chk({nm, "_pc"}, CurrentPC, RST_PC);
    chk({nm, "_instr"}, 64'(instr), 64'd0);
  endtask

  // Monitor: at negedge the inputs are still those the last posedge saw,
  // so combine them with the outputs recorded one negedge earlier.
  logic        l_reqv = 0, l_ivalid = 0;
  logic [63:0] l_addr = '0, l_ipc = '0;
  logic [31:0] l_instr = '0;

  always @(negedge CLK) begin
    exp_t e;
    logic [63:0] a;
    if (Reset) begin
      l_reqv = 0; l_ivalid = 0;
    end else begin
      if (l_reqv && imem_req_ready) begin
        if (addr_q.size() == 0) begin
          chk("unexpected_req", l_addr, 64'hDEAD);
        end else begin
          a = addr_q.pop_front();
          chk("req_addr", l_addr, a);
        end
      end
      if (l_reqv && !imem_req_ready) begin
        chk("req_hold_valid", 64'(imem_req_valid), 64'd1);
        chk("req_hold_addr", imem_addr, l_addr);
      end
      if (l_ivalid && instr_ready) begin
        n_deliv++;
        if (exp_q.size() == 0) begin
          chk("unexpected_instr", l_ipc, 64'hDEAD);
        end else begin
          e = exp_q.pop_front();
          chk("instr_pc", l_ipc, e.pc);
          chk("instr", 64'(l_instr), 64'(e.ins));
        end
        chk("pc_after_accept", CurrentPC, NextPC);
        chk("ivalid_drop", 64'(instr_valid), 64'd0);
        chk("fault_on_accept", 64'(fetch_fault), 64'(NextPC[1:0] != 2'b00));
      end
      if (l_ivalid && !instr_ready) begin
        chk("hold_ivalid", 64'(instr_valid), 64'd1);
        chk("hold_instr", 64'(instr), 64'(l_instr));
        chk("hold_pc", instr_pc, l_ipc);
      end
      if (imem_req_valid && outst) chk("two_outstanding", 64'd1, 64'd0);
      l_reqv   = imem_req_valid;
      l_addr   = imem_addr;
      l_ivalid = instr_valid;
      l_instr  = instr;
      l_ipc    = instr_pc;
    end
  end

  initial begin
    bit was;
    bit hit;
    NextPC = '0; imem_req_ready = 0; imem_rsp_valid = 0; imem_rsp_data = '0; instr_ready = 0;
    Reset = 1'b1;
    #1 chk_reset_outputs("reset");

    // first fetch with zero-wait memory
    do_reset();
    p_rdy = 100; max_lat = 0; p_dec = 0; spur = 0; br = 0;
    step();
    chk("c1_reqv", 64'(imem_req_valid), 64'd1);
    chk("c1_addr", imem_addr, 64'd0);
    step();
    chk("c2_ivalid", 64'(instr_valid), 64'd0);
    step();
    chk("c3_ivalid", 64'(instr_valid), 64'd1);
    chk("c3_instr", 64'(instr), 64'h8B020020);
    chk("c3_ipc", instr_pc, 64'd0);

    // sequential stream
    p_dec = 100;
    for (int i = 0; i < 60 && n_deliv < 5; i++) step();
    chk("seq_progress", 64'(n_deliv >= 5), 64'd1);

    // backpressure on both sides
    p_dec = 0; p_rdy = 0;
    repeat (3) step();
    p_rdy = 100;
    repeat (5) step();
    p_dec = 100;

    // branch to 0x40, then wrap through the top of the address space
    force_pc = 64'h40; force_en = 1;
    for (int i = 0; i < 40 && force_en; i++) step();
    chk("branch_taken", 64'(force_en), 64'd0);
    force_pc = 64'hFFFF_FFFF_FFFF_FFFC; force_en = 1;
    for (int i = 0; i < 40 && force_en; i++) step();
    repeat (12) step();

    // random traffic with stray responses
    p_rdy = 60; max_lat = 3; p_dec = 60; spur = 25; br = 20;
    repeat (400) step();

    // reset while waiting for a response
    hit = 0;
    for (int i = 0; i < 200 && !hit; i++) begin
      was = outst; step(); hit = !was && outst;
    end
    chk("found_wait", 64'(hit), 64'd1);
    @(posedge CLK); #2 Reset = 1'b1;
    #1 chk_reset_outputs("rst_wait");
    do_reset();
    repeat (150) step();

    // reset while holding an instruction for decode
    p_dec = 0;
    hit = 0;
    for (int i = 0; i < 200 && !hit; i++) begin
      step(); hit = instr_valid;
    end
    chk("found_hold", 64'(hit), 64'd1);
    #2 Reset = 1'b1;
    #1 chk_reset_outputs("rst_hold");
    do_reset();
    p_dec = 60;
    repeat (150) step();

    // misaligned next PC becomes a sticky fault
    p_rdy = 100; max_lat = 1; p_dec = 100; spur = 0; mis_en = 1;
    hit = 0;
    for (int i = 0; i < 100 && !hit; i++) begin
      step(); hit = fetch_fault;
    end
    chk("fault_seen", 64'(hit), 64'd1);
    chk("fault_pc", CurrentPC, 64'h42);
    for (int i = 0; i < 5; i++) begin
      step();
      chk("fault_sticky", 64'({fetch_fault, imem_req_valid, instr_valid}), 64'b100);
    end
    mis_en = 0;
    do_reset();
    #1 chk("fault_cleared", 64'(fetch_fault), 64'd0);
    p_rdy = 70; max_lat = 2; p_dec = 70; spur = 20; br = 15;
    repeat (200) step();

    chk("progress", 64'(n_deliv >= 60), 64'd1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
